aes_inv_cipher_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 56 +++++
 rtl/aes_inv_sbox.sv | 21 ++
 rtl/aes_inv_cipher_iter.sv | 128 ++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) constant multiplies for InvMixColumns,
// state byte addressing and the legal key-length/round-count pairs.
package aes_pkg;

  localparam int NK_AES128 = 4;
  localparam int NR_AES128 = 10;
  localparam int NK_AES192 = 6;
  localparam int NR_AES192 = 12;
  localparam int NK_AES256 = 8;
  localparam int NR_AES256 = 14;

  function automatic bit legal_cfg(input int nk, input int nr);
    return (nk == NK_AES128 && nr == NR_AES128) ||
           (nk == NK_AES192 && nr == NR_AES192) ||
           (nk == NK_AES256 && nr == NR_AES256);
  endfunction

  // Multiply by {02} modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    logic [7:0] x2, x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    logic [7:0] x4, x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // LSB position of state byte s(row,col); s(0,0) sits at [127:120].
  function automatic int byte_lsb(input int row, input int col);
    return 120 - 8 * (4 * col + row);
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box, one byte in, one byte out.
module aes_inv_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry 0x00 occupies the top byte, so entry n sits at bit (255-n)*8.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  assign out_byte = INV_SBOX[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock, fed by the
// full expanded key schedule from the key-expansion block.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NB = 4,
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [127:0]            ciphertext,
  input  logic [32*NB*(NR+1)-1:0] w,
  output logic                    out_valid,
  output logic [127:0]            plaintext
);

  localparam int RW = $clog2(NR + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;

  if (!legal_cfg(NK, NR)) begin : g_bad_cfg
    $error("aes_inv_cipher_iter: NK/NR must be 4/10, 6/12 or 8/14");
  end

  logic [1:0]    fsm_q, fsm_d;
  logic [RW-1:0] round_q, round_d;
  logic [127:0]  state_q, state_d;
  logic [127:0]  plaintext_q, plaintext_d;
  logic          out_valid_q, out_valid_d;

  logic [127:0] rk [0:NR];
  logic [127:0] isr, isb, ark, imc;

  // Word 4r is state column 0 of round key r, so it lands in the top 32 bits.
  for (genvar g = 0; g <= NR; g++) begin : g_rk
    assign rk[g] = {w[32*(NB*g)   +: 32], w[32*(NB*g+1) +: 32],
                    w[32*(NB*g+2) +: 32], w[32*(NB*g+3) +: 32]};
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    isr = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        isr[byte_lsb(r, c) +: 8] = state_q[byte_lsb(r, (c - r + 4) % 4) +: 8];
      end
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_inv_sbox (
      .in_byte  (isr[8*i +: 8]),
      .out_byte (isb[8*i +: 8])
    );
  end

  assign ark = isb ^ rk[round_q];

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    imc = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = ark[byte_lsb(0, c) +: 8];
      a1 = ark[byte_lsb(1, c) +: 8];
      a2 = ark[byte_lsb(2, c) +: 8];
      a3 = ark[byte_lsb(3, c) +: 8];
      imc[byte_lsb(0, c) +: 8] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
      imc[byte_lsb(1, c) +: 8] = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
      imc[byte_lsb(2, c) +: 8] = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
      imc[byte_lsb(3, c) +: 8] = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    round_d     = round_q;
    state_d     = state_q;
    plaintext_d = plaintext_q;
    out_valid_d = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ciphertext ^ rk[NR];
          round_d = RW'(NR - 1);
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_d = imc;
        round_d = round_q - RW'(1);
        if (round_q == RW'(1)) fsm_d = ST_FINAL;
      end
      ST_FINAL: begin
        plaintext_d = isb ^ rk[0];
        out_valid_d = 1'b1;
        fsm_d       = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= ST_IDLE;
      round_q     <= '0;
      state_q     <= '0;
      plaintext_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      round_q     <= round_d;
      state_q     <= state_d;
      plaintext_q <= plaintext_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (fsm_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign plaintext = plaintext_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: AES-128/192/256 instances checked against
// FIPS-197 vectors and a byte-array AES model built from GF(2^8) arithmetic.
module tb_aes_inv_cipher_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [2:0]          iv, ir, ov;
  logic [127:0]        ct;
  logic [2:0][127:0]   pt;
  logic [1407:0]       wk0;
  logic [1663:0]       wk1;
  logic [1919:0]       wk2;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [1919:0] wm [3];

  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  logic [127:0] kat_ct [3] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                               128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                               128'h8ea2b7ca516745bfeafc49904b496089};

  aes_inv_cipher_iter #(.NK(4), .NB(4), .NR(10)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .ciphertext(ct),
    .w(wk0), .out_valid(ov[0]), .plaintext(pt[0]));
  aes_inv_cipher_iter #(.NK(6), .NB(4), .NR(12)) u_dut192 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .ciphertext(ct),
    .w(wk1), .out_valid(ov[1]), .plaintext(pt[1]));
  aes_inv_cipher_iter #(.NK(8), .NB(4), .NR(14)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .ciphertext(ct),
    .w(wk2), .out_valid(ov[2]), .plaintext(pt[2]));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[x] = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int nr, output logic [1919:0] wo);
    logic [31:0] wd [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    wo = '0;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) wd[i] = key[255 - 32*i -: 32];
      else begin
        t = wd[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gf_mul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        wd[i] = wd[i-nk] ^ t;
      end
      wo[32*i +: 32] = wd[i];
    end
  endtask

  function automatic logic [127:0] rk_of(input logic [1919:0] wb, input int r);
    return {wb[128*r +: 32], wb[128*r+32 +: 32], wb[128*r+64 +: 32], wb[128*r+96 +: 32]};
  endfunction

  // Column mix with circulant first row m = {m0,m1,m2,m3}.
  function automatic logic [127:0] mix(input logic [127:0] v, input logic [31:0] m);
    logic [127:0] o;
    logic [7:0] acc;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gf_mul(m[31 - 8*((k - r + 4) % 4) -: 8], v[127 - 8*(4*c+k) -: 8]);
        o[127 - 8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [127:0] blk, input logic [1919:0] wb, input int nr);
    logic [127:0] v, o;
    v = blk ^ rk_of(wb, nr);
    for (int rnd = nr - 1; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          o[127 - 8*(4*c+r) -: 8] = isb[v[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]];
      v = o ^ rk_of(wb, rnd);
      if (rnd > 0) v = mix(v, 32'h0e0b0d09);
    end
    return v;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] blk, input logic [1919:0] wb, input int nr);
    logic [127:0] v, o;
    v = blk ^ rk_of(wb, 0);
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          o[127 - 8*(4*c+r) -: 8] = sb[v[127 - 8*(4*((c + r) % 4) + r) -: 8]];
      v = (rnd < nr) ? mix(o, 32'h02030101) : o;
      v = v ^ rk_of(wb, rnd);
    end
    return v;
  endfunction

  // ---------------- bench helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input int k, input logic [255:0] key);
    expand(key, 4 + 2*k, 10 + 2*k, wm[k]);
    case (k)
      0:       wk0 = wm[0][1407:0];
      1:       wk1 = wm[1][1663:0];
      default: wk2 = wm[2];
    endcase
  endtask

  task automatic wait_done(input int k, output logic [127:0] res, output int lat, output bit rdy_low);
    lat = 0;
    rdy_low = 1'b1;
    while (ov[k] !== 1'b1 && lat < 40) begin
      if (ir[k] !== 1'b0) rdy_low = 1'b0;
      tick();
      lat++;
    end
    res = pt[k];
  endtask

  task automatic run_block(input int k, input logic [127:0] c, output logic [127:0] res,
                           output int lat, output bit rdy_low);
    ct = c;
    iv[k] = 1'b1;
    tick();
    iv[k] = 1'b0;
    wait_done(k, res, lat, rdy_low);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] res, c2, rnd_ct;
    logic [255:0] rnd_key;
    int lat, pulses;
    bit rl;

    build_sbox();
    rst_n = 1'b0;
    iv = '0;
    ct = '0;
    for (int k = 0; k < 3; k++) set_key(k, FIPS_KEY);
    #22 rst_n = 1'b1;
    tick();

    for (int k = 0; k < 3; k++) begin
      chk("reset_in_ready", 128'(ir[k]), 128'd1);
      chk("reset_out_valid", 128'(ov[k]), 128'd0);
      chk("reset_plaintext", pt[k], 128'd0);
    end

    // FIPS-197 known answers for all three key sizes
    for (int k = 0; k < 3; k++) begin
      run_block(k, kat_ct[k], res, lat, rl);
      chk("kat_plaintext", res, FIPS_PT);
      chk("kat_latency", 128'(lat), 128'(10 + 2*k));
      chk("kat_busy_not_ready", 128'(rl), 128'd1);
      chk("kat_ready_with_valid", 128'(ir[k]), 128'd1);
      tick();
      chk("kat_single_pulse", 128'(ov[k]), 128'd0);
    end

    // Random keys and ciphertexts against the model
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 3; n++) begin
        rnd_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        rnd_ct  = {$urandom, $urandom, $urandom, $urandom};
        set_key(k, rnd_key);
        run_block(k, rnd_ct, res, lat, rl);
        chk("rand_plaintext", res, ref_decrypt(rnd_ct, wm[k], 10 + 2*k));
        chk("rand_latency", 128'(lat), 128'(10 + 2*k));
        tick();
      end
      set_key(k, FIPS_KEY);
    end

    // Back-to-back: second in_valid held high while the first block runs
    c2 = ref_encrypt(128'h0, wm[0], 10);
    ct = kat_ct[0];
    iv[0] = 1'b1;
    tick();
    ct = c2;
    wait_done(0, res, lat, rl);
    chk("b2b_first_plaintext", res, FIPS_PT);
    chk("b2b_first_latency", 128'(lat), 128'd10);
    chk("b2b_first_busy", 128'(rl), 128'd1);
    chk("b2b_ready_with_valid", 128'(ir[0]), 128'd1);
    tick();
    iv[0] = 1'b0;
    chk("b2b_second_accepted", 128'(ir[0]), 128'd0);
    chk("b2b_valid_cleared", 128'(ov[0]), 128'd0);
    wait_done(0, res, lat, rl);
    chk("b2b_second_plaintext", res, 128'h0);
    chk("b2b_second_latency", 128'(lat), 128'd10);
    chk("b2b_second_busy", 128'(rl), 128'd1);
    tick();

    // in_valid pulse during ROUND must be ignored
    ct = kat_ct[0];
    iv[0] = 1'b1;
    tick();
    pulses = 0;
    res = '0;
    for (int i = 0; i < 25; i++) begin
      iv[0] = (i == 3);
      if (i == 3) ct = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (ov[0] === 1'b1) begin
        pulses++;
        res = pt[0];
      end
    end
    iv[0] = 1'b0;
    chk("busy_ignore_plaintext", res, FIPS_PT);
    chk("busy_ignore_pulses", 128'(pulses), 128'd1);

    // Asynchronous reset at round 5
    ct = kat_ct[0];
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    repeat (4) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 128'(ov[0]), 128'd0);
    chk("midreset_plaintext", pt[0], 128'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("midreset_in_ready", 128'(ir[0]), 128'd1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (ov[0] !== 1'b0) pulses++;
      tick();
    end
    chk("midreset_no_stray_valid", 128'(pulses), 128'd0);
    run_block(0, kat_ct[0], res, lat, rl);
    chk("post_reset_plaintext", res, FIPS_PT);
    chk("post_reset_latency", 128'(lat), 128'd10);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
